// File: rtl/seq_mul.sv
// rtl/seq_mul.sv - iterative shift-and-add multiplier, signed/unsigned, start/busy/done handshake
module seq_mul #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               sgn,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] p
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               neg;
    logic [2*WIDTH-1:0] acc;
    logic [CNT_W-1:0]   count;

    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] addend;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [2*WIDTH-1:0] p_nxt;
    logic               last_iter;

    // Magnitudes stay WIDTH-bit unsigned so |-2^(W-1)| = 2^(W-1) is not re-sign-extended.
    always_comb begin
        a_neg = sgn & a[WIDTH-1];
        b_neg = sgn & b[WIDTH-1];
        a_mag = a;
        b_mag = b;
        if (a_neg) begin
            a_mag = ~a + 1'b1;
        end
        if (b_neg) begin
            b_mag = ~b + 1'b1;
        end
    end

    always_comb begin
        addend  = '0;
        if (mag_b[0]) begin
            addend = {{WIDTH{1'b0}}, mag_a} << count;
        end
        acc_nxt = acc + addend;
        p_nxt   = acc_nxt;
        if (neg) begin
            p_nxt = ~acc_nxt + 1'b1;
        end
    end

    assign last_iter = (count == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last_iter) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mag_a <= '0;
            mag_b <= '0;
            neg   <= 1'b0;
            acc   <= '0;
            count <= '0;
            p     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mag_a <= a_mag;
                        mag_b <= b_mag;
                        neg   <= a_neg ^ b_neg;
                        acc   <= '0;
                        count <= '0;
                    end
                end
                RUN: begin
                    acc   <= acc_nxt;
                    mag_b <= mag_b >> 1;
                    count <= count + 1'b1;
                    if (last_iter) begin
                        p <= p_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mul.sv
// tb/tb_seq_mul.sv - directed-vector bench for seq_mul at WIDTH=8 and WIDTH=3
module tb_seq_mul;

    logic        clk = 1'b0;
    logic        rst;

    logic        start8, s8, busy8, done8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;

    logic        start3, busy3, done3;
    logic [2:0]  a3, b3;
    logic [5:0]  p3;

    logic [15:0] last_p;
    logic [5:0]  last_p3;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    seq_mul #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .sgn   (s8),
        .a     (a8),
        .b     (b8),
        .busy  (busy8),
        .done  (done8),
        .p     (p8)
    );

    seq_mul #(.WIDTH(3)) dut3 (
        .clk   (clk),
        .rst   (rst),
        .start (start3),
        .sgn   (1'b0),
        .a     (a3),
        .b     (b3),
        .busy  (busy3),
        .done  (done3),
        .p     (p3)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op8(input string tag, input logic s, input logic [7:0] x,
                       input logic [7:0] y, input logic [15:0] exp);
        int lat;
        s8 = s; a8 = x; b8 = y; start8 = 1'b1;
        tick();
        start8 = 1'b0; s8 = ~s; a8 = ~x; b8 = ~y;
        lat = 0;
        while (!done8 && lat < 20) begin
            check({tag, "_busy"}, 64'(busy8), 64'(1));
            check({tag, "_hold"}, 64'(p8), 64'(last_p));
            tick();
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'(8));
        check({tag, "_excl"}, 64'(busy8), 64'(0));
        check({tag, "_p"}, 64'(p8), 64'(exp));
        last_p = exp;
        tick();
        check({tag, "_pulse"}, 64'(done8), 64'(0));
    endtask

    task automatic op3(input string tag, input logic [2:0] x, input logic [2:0] y,
                       input logic [5:0] exp);
        int lat;
        a3 = x; b3 = y; start3 = 1'b1;
        tick();
        start3 = 1'b0;
        lat = 0;
        while (!done3 && lat < 10) begin
            check({tag, "_hold"}, 64'(p3), 64'(last_p3));
            tick();
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'(3));
        check({tag, "_p"}, 64'(p3), 64'(exp));
        last_p3 = exp;
        tick();
    endtask

    task automatic wait_done8(input string tag);
        int n;
        n = 0;
        while (!done8 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_seen"}, 64'(done8), 64'(1));
    endtask

    initial begin
        int dones;
        int first_done;
        int second_done;
        logic [15:0] e;
        logic [7:0]  rx, ry;
        logic        rs;

        rst = 1'b1; start8 = 1'b0; s8 = 1'b0; a8 = '0; b8 = '0;
        start3 = 1'b0; a3 = '0; b3 = '0;
        last_p = '0; last_p3 = '0;
        tick(); tick();
        check("rst_busy", 64'(busy8), 64'(0));
        check("rst_done", 64'(done8), 64'(0));
        check("rst_p", 64'(p8), 64'(0));
        rst = 1'b0;
        tick();

        op3("w3_7x7", 3'd7, 3'd7, 6'd49);
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                op3("w3_sweep", 3'(i), 3'(j), 6'(i * j));
            end
        end

        op8("u_ff_ff", 1'b0, 8'hFF, 8'hFF, 16'hFE01);
        op8("u_0_c8",  1'b0, 8'h00, 8'hC8, 16'h0000);
        op8("u_fd_05", 1'b0, 8'hFD, 8'h05, 16'h04F1);
        op8("u_0c_0a", 1'b0, 8'h0C, 8'h0A, 16'h0078);
        op8("u_80_80", 1'b0, 8'h80, 8'h80, 16'h4000);
        op8("s_fd_05", 1'b1, 8'hFD, 8'h05, 16'hFFF1);
        op8("s_80_80", 1'b1, 8'h80, 8'h80, 16'h4000);
        op8("s_80_7f", 1'b1, 8'h80, 8'h7F, 16'hC080);
        op8("s_00_ff", 1'b1, 8'h00, 8'hFF, 16'h0000);
        op8("s_ff_ff", 1'b1, 8'hFF, 8'hFF, 16'h0001);
        op8("s_7f_7f", 1'b1, 8'h7F, 8'h7F, 16'h3F01);
        op8("s_05_fd", 1'b1, 8'h05, 8'hFD, 16'hFFF1);

        // start pulsed with new operands while busy must be ignored
        s8 = 1'b0; a8 = 8'd10; b8 = 8'd20; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick(); tick();
        s8 = 1'b1; a8 = 8'd99; b8 = 8'd77; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        wait_done8("hs");
        check("hs_p", 64'(p8), 64'(16'd200));
        last_p = 16'd200;
        dones = 0;
        for (int k = 0; k < 14; k++) begin
            tick();
            if (done8) dones++;
        end
        check("hs_no_second_done", 64'(dones), 64'(0));

        // start held high: one accepted op per WIDTH+2 cycles
        s8 = 1'b0; a8 = 8'd3; b8 = 8'd5; start8 = 1'b1;
        first_done = -1; second_done = -1;
        for (int k = 0; k < 35; k++) begin
            tick();
            if (done8) begin
                if (first_done < 0) first_done = k;
                else if (second_done < 0) second_done = k;
            end
        end
        start8 = 1'b0;
        check("held_first", 64'(first_done), 64'(8));
        check("held_spacing", 64'(second_done - first_done), 64'(10));
        check("held_p", 64'(p8), 64'(16'd15));
        repeat (12) tick();
        last_p = 16'd15;

        // reset after 4 of 8 iterations discards the operation
        s8 = 1'b0; a8 = 8'd100; b8 = 8'd3; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_busy", 64'(busy8), 64'(0));
        check("mid_rst_done", 64'(done8), 64'(0));
        check("mid_rst_p", 64'(p8), 64'(0));
        last_p = '0;
        last_p3 = '0;
        dones = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (done8) dones++;
        end
        check("mid_rst_no_done", 64'(dones), 64'(0));
        op8("post_rst", 1'b0, 8'd100, 8'd3, 16'h012C);

        for (int k = 0; k < 150; k++) begin
            rx = 8'($urandom);
            ry = 8'($urandom);
            rs = 1'($urandom);
            if (rs) e = 16'($signed(rx) * $signed(ry));
            else    e = 16'(rx * ry);
            op8("rand", rs, rx, ry, e);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
